// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester round-robin arbiter in front of a single genrom
// read port. One transaction in flight at a time; each grant produces exactly
// one response two cycles later, routed back to the requester that won.
module mem_arbiter #(
    parameter int MEM_ADDR  = 4,
    parameter int MEM_EXTRA = 4,
    localparam int DW       = (2 ** MEM_EXTRA) * 8
) (
    input  logic                 clk,
    input  logic                 reset,
    // fetch requester
    input  logic                 f_req,
    input  logic [MEM_ADDR:0]    f_addr,
    input  logic [MEM_EXTRA-1:0] f_extra,
    output logic                 f_gnt,
    output logic                 f_valid,
    output logic [DW-1:0]        f_data,
    output logic                 f_error,
    // data requester
    input  logic                 d_req,
    input  logic [MEM_ADDR:0]    d_addr,
    input  logic [MEM_EXTRA-1:0] d_extra,
    output logic                 d_gnt,
    output logic                 d_valid,
    output logic [DW-1:0]        d_data,
    output logic                 d_error,
    // shared genrom port
    output logic [MEM_ADDR:0]    mem_addr,
    output logic [MEM_EXTRA-1:0] mem_extra,
    input  logic [DW-1:0]        mem_data,
    input  logic                 mem_error,
    output logic                 busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic                 owner_q, owner_d;   // 0 = fetch, 1 = data
    logic                 last_q, last_d;     // last granted requester
    logic [MEM_ADDR:0]    addr_q, addr_d;
    logic [MEM_EXTRA-1:0] extra_q, extra_d;

    logic accept;
    logic win_data;

    // Round-robin pick and acceptance window (IDLE or RESP, never during reset)
    always_comb begin
        if (f_req && d_req) begin
            win_data = ~last_q;
        end else begin
            win_data = d_req;
        end
        accept = !reset && (state_q == IDLE || state_q == RESP) && (f_req || d_req);
    end

    // State and latched-request registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
            addr_q  <= '0;
            extra_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            addr_q  <= addr_d;
            extra_q <= extra_d;
        end
    end

    // Next-state: ISSUE always lasts one cycle; RESP chains straight into ISSUE on a new accept
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        addr_d  = addr_q;
        extra_d = extra_q;
        case (state_q)
            IDLE:    state_d = accept ? ISSUE : IDLE;
            ISSUE:   state_d = RESP;
            RESP:    state_d = accept ? ISSUE : IDLE;
            default: state_d = IDLE;
        endcase
        if (accept) begin
            owner_d = win_data;
            last_d  = win_data;
            addr_d  = win_data ? d_addr  : f_addr;
            extra_d = win_data ? d_extra : f_extra;
        end
    end

    // Outputs: grants are combinational; responses pass genrom data through in RESP
    always_comb begin
        f_gnt     = accept && !win_data;
        d_gnt     = accept &&  win_data;
        f_valid   = !reset && (state_q == RESP) && !owner_q;
        d_valid   = !reset && (state_q == RESP) &&  owner_q;
        f_error   = f_valid && mem_error;
        d_error   = d_valid && mem_error;
        f_data    = mem_data;
        d_data    = mem_data;
        busy      = !reset && (state_q != IDLE);
        mem_addr  = addr_q;
        mem_extra = extra_q;
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed per-cycle vector table followed by random
// traffic checked against a cycle-numbered transaction model.
module tb_mem_arbiter;

    localparam int MA = 4;
    localparam int ME = 4;
    localparam int DW = (2 ** ME) * 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          f_req, d_req;
    logic [MA:0]   f_addr, d_addr;
    logic [ME-1:0] f_extra, d_extra;
    logic          f_gnt, f_valid, f_error;
    logic          d_gnt, d_valid, d_error;
    logic [DW-1:0] f_data, d_data;
    logic [MA:0]   mem_addr;
    logic [ME-1:0] mem_extra;
    logic [DW-1:0] mem_data;
    logic          mem_error;
    logic          busy;

    int checks   = 0;
    int failures = 0;

    mem_arbiter #(.MEM_ADDR(MA), .MEM_EXTRA(ME)) dut (
        .clk(clk), .reset(reset),
        .f_req(f_req), .f_addr(f_addr), .f_extra(f_extra),
        .f_gnt(f_gnt), .f_valid(f_valid), .f_data(f_data), .f_error(f_error),
        .d_req(d_req), .d_addr(d_addr), .d_extra(d_extra),
        .d_gnt(d_gnt), .d_valid(d_valid), .d_data(d_data), .d_error(d_error),
        .mem_addr(mem_addr), .mem_extra(mem_extra),
        .mem_data(mem_data), .mem_error(mem_error), .busy(busy)
    );

    always #5 clk = ~clk;

    // genrom stand-in: each byte depends on address, extra and byte lane
    function automatic logic [DW-1:0] rom_word(input logic [MA:0] a, input logic [ME-1:0] e);
        logic [DW-1:0] w;
        int v;
        for (int i = 0; i < DW / 8; i++) begin
            v = int'(a) * 8 + int'(e) * 3 + i * 17;
            w[i*8 +: 8] = v[7:0];
        end
        return w;
    endfunction

    function automatic logic rom_err(input logic [MA:0] a);
        return a >= 5'd30;
    endfunction

    // genrom answers one clock after sampling the address
    always @(posedge clk) begin
        mem_data  <= rom_word(mem_addr, mem_extra);
        mem_error <= rom_err(mem_addr);
    end

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input bit rst, input bit fr, input logic [MA:0] fa, input logic [ME-1:0] fe,
                         input bit dr, input logic [MA:0] da, input logic [ME-1:0] de);
        reset   = rst;
        f_req   = fr;
        f_addr  = fa;
        f_extra = fe;
        d_req   = dr;
        d_addr  = da;
        d_extra = de;
    endtask

    task automatic compare(input string tag, input bit e_fg, input bit e_dg, input bit e_fv,
                           input bit e_dv, input bit e_fer, input bit e_der, input bit e_bsy,
                           input bit chk_ma, input logic [MA:0] e_ma, input logic [DW-1:0] e_data);
        chk({tag, ".f_gnt"},   DW'(f_gnt),   DW'(e_fg));
        chk({tag, ".d_gnt"},   DW'(d_gnt),   DW'(e_dg));
        chk({tag, ".f_valid"}, DW'(f_valid), DW'(e_fv));
        chk({tag, ".d_valid"}, DW'(d_valid), DW'(e_dv));
        chk({tag, ".f_error"}, DW'(f_error), DW'(e_fer));
        chk({tag, ".d_error"}, DW'(d_error), DW'(e_der));
        chk({tag, ".busy"},    DW'(busy),    DW'(e_bsy));
        if (chk_ma) chk({tag, ".mem_addr"}, DW'(mem_addr), DW'(e_ma));
        if (e_fv)   chk({tag, ".f_data"}, f_data, e_data);
        if (e_dv)   chk({tag, ".d_data"}, d_data, e_data);
    endtask

    typedef struct {
        bit          rst, fr, dr;
        logic [MA:0] fa, da;
        logic [ME-1:0] fe, de;
        bit          fg, dg, fv, dv, bsy;
        bit          cm;
        logic [MA:0] ma;
        logic [MA:0] va;
        logic [ME-1:0] ve;
    } vec_t;

    function automatic vec_t V(input bit rst, input bit fr, input int fa, input int fe,
                               input bit dr, input int da, input int de,
                               input bit fg, input bit dg, input bit fv, input bit dv, input bit bsy,
                               input bit cm, input int ma, input int va, input int ve);
        vec_t r;
        r.rst = rst; r.fr = fr; r.fa = 5'(fa); r.fe = 4'(fe);
        r.dr = dr;   r.da = 5'(da); r.de = 4'(de);
        r.fg = fg; r.dg = dg; r.fv = fv; r.dv = dv; r.bsy = bsy;
        r.cm = cm; r.ma = 5'(ma); r.va = 5'(va); r.ve = 4'(ve);
        return r;
    endfunction

    vec_t tbl[$];

    // random-phase model state: one outstanding transaction keyed by its response cycle
    bit          m_pend;
    int          m_resp;
    bit          m_owner;
    logic [MA:0] m_addr;
    logic [ME-1:0] m_ext;
    bit          m_last;
    logic [MA:0] m_ma;

    initial begin
        //           rst fr fa fe dr da de | fg dg fv dv bsy | cm ma | va ve
        tbl.push_back(V(1, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0,  0, 0,  0, 0));
        tbl.push_back(V(1, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0,  1, 0,  0, 0));
        // single fetch of address 3
        tbl.push_back(V(0, 1, 3, 0, 0, 0, 0,  1, 0, 0, 0, 0,  1, 0,  0, 0));
        tbl.push_back(V(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 1,  1, 3,  0, 0));
        tbl.push_back(V(0, 0, 0, 0, 0, 0, 0,  0, 0, 1, 0, 1,  1, 3,  3, 0));
        tbl.push_back(V(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0,  1, 3,  0, 0));
        // fetch re-requests in its own response cycle
        tbl.push_back(V(0, 1, 5, 2, 0, 0, 0,  1, 0, 0, 0, 0,  1, 3,  0, 0));
        tbl.push_back(V(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 1,  1, 5,  0, 0));
        tbl.push_back(V(0, 1, 7, 1, 0, 0, 0,  1, 0, 1, 0, 1,  1, 5,  5, 2));
        tbl.push_back(V(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 1,  1, 7,  0, 0));
        tbl.push_back(V(0, 0, 0, 0, 0, 0, 0,  0, 0, 1, 0, 1,  1, 7,  7, 1));
        tbl.push_back(V(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0,  1, 7,  0, 0));
        // data read that raises a genrom error, then a clean fetch
        tbl.push_back(V(0, 0, 0, 0, 1, 30, 3, 0, 1, 0, 0, 0,  1, 7,  0, 0));
        tbl.push_back(V(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 1,  1, 30, 0, 0));
        tbl.push_back(V(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 1, 1,  1, 30, 30, 3));
        tbl.push_back(V(0, 1, 2, 0, 0, 0, 0,  1, 0, 0, 0, 0,  1, 30, 0, 0));
        tbl.push_back(V(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 1,  1, 2,  0, 0));
        tbl.push_back(V(0, 0, 0, 0, 0, 0, 0,  0, 0, 1, 0, 1,  1, 2,  2, 0));
        // data grant sets pointer to data; tie then goes to fetch, data drops out
        tbl.push_back(V(0, 0, 0, 0, 1, 1, 0,  0, 1, 0, 0, 0,  1, 2,  0, 0));
        tbl.push_back(V(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 1,  1, 1,  0, 0));
        tbl.push_back(V(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 1, 1,  1, 1,  1, 0));
        tbl.push_back(V(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0,  1, 1,  0, 0));
        tbl.push_back(V(0, 1, 10, 4, 1, 11, 5, 1, 0, 0, 0, 0, 1, 1,  0, 0));
        tbl.push_back(V(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 1,  1, 10, 0, 0));
        tbl.push_back(V(0, 0, 0, 0, 0, 0, 0,  0, 0, 1, 0, 1,  1, 10, 10, 4));
        // pointer advanced for the fetch: next tie goes to data
        tbl.push_back(V(0, 1, 12, 0, 1, 13, 6, 0, 1, 0, 0, 0, 1, 10, 0, 0));
        tbl.push_back(V(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 1,  1, 13, 0, 0));
        tbl.push_back(V(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 1, 1,  1, 13, 13, 6));
        // both requesters held high across reset release: F, D, F, D
        tbl.push_back(V(1, 1, 4, 1, 1, 9, 2,  0, 0, 0, 0, 0,  0, 0,  0, 0));
        tbl.push_back(V(0, 1, 4, 1, 1, 9, 2,  1, 0, 0, 0, 0,  1, 0,  0, 0));
        tbl.push_back(V(0, 1, 4, 1, 1, 9, 2,  0, 0, 0, 0, 1,  1, 4,  0, 0));
        tbl.push_back(V(0, 1, 4, 1, 1, 9, 2,  0, 1, 1, 0, 1,  1, 4,  4, 1));
        tbl.push_back(V(0, 1, 4, 1, 1, 9, 2,  0, 0, 0, 0, 1,  1, 9,  0, 0));
        tbl.push_back(V(0, 1, 4, 1, 1, 9, 2,  1, 0, 0, 1, 1,  1, 9,  9, 2));
        tbl.push_back(V(0, 1, 4, 1, 1, 9, 2,  0, 0, 0, 0, 1,  1, 4,  0, 0));
        tbl.push_back(V(0, 1, 4, 1, 1, 9, 2,  0, 1, 1, 0, 1,  1, 4,  4, 1));
        // reset while the data read is in ISSUE: abandoned, fetch granted right after
        tbl.push_back(V(1, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0,  0, 0,  0, 0));
        tbl.push_back(V(0, 1, 6, 0, 0, 0, 0,  1, 0, 0, 0, 0,  1, 0,  0, 0));
        tbl.push_back(V(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 1,  1, 6,  0, 0));
        tbl.push_back(V(0, 0, 0, 0, 0, 0, 0,  0, 0, 1, 0, 1,  1, 6,  6, 0));
        tbl.push_back(V(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0,  1, 6,  0, 0));
        // reset during RESP suppresses the response
        tbl.push_back(V(0, 0, 0, 0, 1, 8, 7,  0, 1, 0, 0, 0,  1, 6,  0, 0));
        tbl.push_back(V(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 1,  1, 8,  0, 0));
        tbl.push_back(V(1, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0,  0, 0,  0, 0));
        tbl.push_back(V(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0,  1, 0,  0, 0));
        tbl.push_back(V(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0,  1, 0,  0, 0));

        drive(1, 0, '0, '0, 0, '0, '0);
        @(posedge clk);
        #1;

        foreach (tbl[i]) begin
            drive(tbl[i].rst, tbl[i].fr, tbl[i].fa, tbl[i].fe, tbl[i].dr, tbl[i].da, tbl[i].de);
            @(negedge clk);
            compare($sformatf("vec%0d", i), tbl[i].fg, tbl[i].dg, tbl[i].fv, tbl[i].dv,
                    tbl[i].fv && rom_err(tbl[i].va), tbl[i].dv && rom_err(tbl[i].va),
                    tbl[i].bsy, tbl[i].cm, tbl[i].ma, rom_word(tbl[i].va, tbl[i].ve));
            @(posedge clk);
            #1;
        end

        // random traffic against the transaction model
        m_pend = 0; m_resp = 0; m_owner = 0; m_addr = '0; m_ext = '0; m_last = 1; m_ma = '0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            bit rst, fr, dr, ev, can, acc, wd;
            logic [MA:0] fa, da;
            logic [ME-1:0] fe, de;
            rst = (cyc == 0) || ($urandom_range(0, 39) == 0);
            fr  = ($urandom_range(0, 2) != 0);
            dr  = ($urandom_range(0, 2) != 0);
            fa  = 5'($urandom_range(0, 31));
            da  = 5'($urandom_range(0, 31));
            fe  = 4'($urandom_range(0, 15));
            de  = 4'($urandom_range(0, 15));
            drive(rst, fr, fa, fe, dr, da, de);
            @(negedge clk);
            if (rst) begin
                compare($sformatf("rnd%0d", cyc), 0, 0, 0, 0, 0, 0, 0, 0, '0, '0);
                m_pend = 0;
                m_last = 1;
                m_ma   = '0;
            end else begin
                ev  = m_pend && (cyc == m_resp);
                can = !m_pend || ev;
                acc = can && (fr || dr);
                wd  = (fr && dr) ? !m_last : dr;
                compare($sformatf("rnd%0d", cyc), acc && !wd, acc && wd,
                        ev && !m_owner, ev && m_owner,
                        ev && !m_owner && rom_err(m_addr), ev && m_owner && rom_err(m_addr),
                        m_pend, 1, m_ma, rom_word(m_addr, m_ext));
                if (ev) m_pend = 0;
                if (acc) begin
                    m_pend  = 1;
                    m_resp  = cyc + 2;
                    m_owner = wd;
                    m_last  = wd;
                    m_addr  = wd ? da : fa;
                    m_ext   = wd ? de : fe;
                    m_ma    = m_addr;
                end
            end
            @(posedge clk);
            #1;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
